// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: walks a low row drive, samples synchronised columns,
// and debounces whole-keypad sweeps into a single press strobe per keypress.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t           state, state_next;
    logic [3:0]       col_meta, col_sync;
    logic [DIV_W-1:0] divider;
    logic [1:0]       row_idx, row_next;
    logic             slot_end, sweep_end;
    logic [1:0]       acc_lows, sweep_lows;
    logic [3:0]       acc_code, sweep_code;
    logic [2:0]       slot_lows, lows_sum;
    logic [1:0]       slot_col;
    logic [3:0]       cand, cand_next, code_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             pressed_next, held_next;

    assign slot_end  = (divider == DIV_LAST);
    assign sweep_end = slot_end && (row_idx == 2'd3);
    assign row_next  = slot_end ? row_idx + 2'd1 : row_idx;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Sweep accumulator: low counts saturate at 2 since MULTI is all that matters beyond one.
    always_comb begin
        slot_lows = 3'd0;
        slot_col  = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync[c]) begin
                slot_lows = slot_lows + 3'd1;
                slot_col  = 2'(c);
            end
        end
        lows_sum   = ((row_idx == 2'd0) ? 3'd0 : {1'b0, acc_lows}) + slot_lows;
        sweep_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        sweep_code = (slot_lows != 3'd0) ? {row_idx, slot_col} : acc_code;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            divider  <= '0;
            row_idx  <= 2'd0;
            rows     <= 4'b1111;
            acc_lows <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            col_meta <= cols;
            col_sync <= col_meta;
            divider  <= slot_end ? '0 : divider + DIV_W'(1);
            row_idx  <= row_next;
            rows     <= ~(4'b0001 << row_next);
            if (slot_end) begin
                acc_lows <= sweep_lows;
                acc_code <= sweep_code;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state       <= IDLE;
            cand        <= 4'd0;
            cnt         <= '0;
            key_code    <= 4'd0;
            key_pressed <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_next;
            cand        <= cand_next;
            cnt         <= cnt_next;
            key_code    <= code_next;
            key_pressed <= pressed_next;
            key_held    <= held_next;
        end
    end

    // Debounce decisions happen only once per sweep, on the row-3 sample cycle.
    always_comb begin
        state_next   = state;
        cand_next    = cand;
        cnt_next     = cnt;
        code_next    = key_code;
        pressed_next = 1'b0;
        held_next    = key_held;
        if (sweep_end) begin
            case (state)
                IDLE: begin
                    if (sweep_lows == 2'd1) begin
                        state_next = DEBOUNCE;
                        cand_next  = sweep_code;
                        cnt_next   = CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (sweep_lows == 2'd1) begin
                        if (sweep_code == cand) begin
                            if (cnt_inc == CNT_DONE) begin
                                code_next    = cand;
                                pressed_next = 1'b1;
                                held_next    = 1'b1;
                                state_next   = HELD;
                                cnt_next     = '0;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end else begin
                            cand_next = sweep_code;
                            cnt_next  = CNT_ONE;
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (sweep_lows == 2'd0) begin
                        state_next = RELEASE;
                        cnt_next   = CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (sweep_lows == 2'd0) begin
                        if (cnt_inc == CNT_DONE) begin
                            held_next  = 1'b0;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
